mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU = m0, DMA = m1), the arbiter and
// the memory-side steering logic. The slave view belongs to the arbiter and the
// master view to everything around it.
interface mem_arbiter_if;
    // requester 0 (CPU)
    logic        m0_stb;
    logic        m0_we;
    logic [1:0]  m0_sel;
    logic [21:1] m0_adr;
    logic [15:0] m0_out;
    logic        m0_ack;
    logic [15:0] m0_dat;
    // requester 1 (DMA)
    logic        m1_stb;
    logic        m1_we;
    logic [1:0]  m1_sel;
    logic [21:1] m1_adr;
    logic [15:0] m1_out;
    logic        m1_ack;
    logic [15:0] m1_dat;
    // memory side
    logic        mem_stb;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [21:1] mem_adr;
    logic [15:0] mem_out;
    logic        mem_ack;
    logic [15:0] mem_dat;
    logic        mem_ready;
    // status
    logic [1:0]  gnt;
    logic        err;

    modport slave (
        input  m0_stb, m0_we, m0_sel, m0_adr, m0_out,
        input  m1_stb, m1_we, m1_sel, m1_adr, m1_out,
        input  mem_ack, mem_dat, mem_ready,
        output m0_ack, m0_dat, m1_ack, m1_dat,
        output mem_stb, mem_we, mem_sel, mem_adr, mem_out,
        output gnt, err
    );

    modport master (
        output m0_stb, m0_we, m0_sel, m0_adr, m0_out,
        output m1_stb, m1_we, m1_sel, m1_adr, m1_out,
        output mem_ack, mem_dat, mem_ready,
        input  m0_ack, m0_dat, m1_ack, m1_dat,
        input  mem_stb, mem_we, mem_sel, mem_adr, mem_out,
        input  gnt, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. One transaction at a time: grant in IDLE,
// hold the request in BUSY until mem_ack or timeout, pulse the owner's ack in
// DONE, then wait in REL for the owner to drop its strobe so a single strobe
// is never served twice.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,   // 2..65535 unacknowledged cycles
    parameter bit          RR_EN   = 1'b1   // 1 = round robin, 0 = m0 always wins ties
) (
    input  logic         clk_p,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_REL  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_tmo_cnt;
    logic        r_last;        // 1 = m1 served last, 0 = m0 served last
    logic [1:0]  r_gnt;
    logic        r_we;
    logic [1:0]  r_sel;
    logic [21:1] r_adr;
    logic [15:0] r_out;
    logic        r_err;

    // requester signals gathered into arrays indexed by requester number
    logic [1:0]       w_stb;
    logic [1:0]       w_we;
    logic [1:0]       w_sel [2];
    logic [21:1]      w_adr [2];
    logic [15:0]      w_out [2];
    logic [1:0][15:0] w_dat;
    logic [1:0]       w_ack;
    logic             w_mem_stb;

    logic w_win;
    logic w_owner_stb;
    logic w_expire;
    logic w_grant;
    logic w_finish;
    logic w_release;

    assign w_stb    = {bus.m1_stb, bus.m0_stb};
    assign w_we     = {bus.m1_we, bus.m0_we};
    assign w_sel[0] = bus.m0_sel;
    assign w_sel[1] = bus.m1_sel;
    assign w_adr[0] = bus.m0_adr;
    assign w_adr[1] = bus.m1_adr;
    assign w_out[0] = bus.m0_out;
    assign w_out[1] = bus.m1_out;

    // winner selection: a lone request wins; a tie goes to the requester not served last (or m0)
    always_comb begin
        w_win = 1'b0;
        if (w_stb == 2'b11)
            w_win = RR_EN ? ~r_last : 1'b0;
        else
            w_win = w_stb[1];
    end

    assign w_owner_stb = w_stb[r_gnt[1]];
    assign w_expire    = (r_tmo_cnt == TMO_LAST);
    assign w_grant     = (r_state == S_IDLE) && bus.mem_ready && (|w_stb);
    assign w_finish    = (r_state == S_BUSY) && (bus.mem_ack || w_expire);
    assign w_release   = (r_state == S_REL) && !w_owner_stb;

    // state register
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_grant)   w_state_next = S_BUSY;
            S_BUSY: if (w_finish)  w_state_next = S_DONE;
            S_DONE:                w_state_next = S_REL;
            S_REL:  if (w_release) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    // output decode: strobe while BUSY, owner's ack during the single DONE cycle
    always_comb begin
        w_mem_stb = 1'b0;
        w_ack     = 2'b00;
        case (r_state)
            S_BUSY:  w_mem_stb = 1'b1;
            S_DONE:  w_ack     = r_gnt;
            default: ;
        endcase
    end

    // timeout counter runs from 0 only while BUSY
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)
            r_tmo_cnt <= '0;
        else if (r_state == S_BUSY)
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        else
            r_tmo_cnt <= '0;
    end

    // latch the winner's request and ownership on the grant edge; drop ownership on release
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt  <= 2'b00;
            r_last <= 1'b1;
            r_we   <= 1'b0;
            r_sel  <= 2'b00;
            r_adr  <= '0;
            r_out  <= '0;
        end else if (w_grant) begin
            r_gnt  <= w_win ? 2'b10 : 2'b01;
            r_last <= w_win;
            r_we   <= w_we[w_win];
            r_sel  <= w_we[w_win] ? w_sel[w_win] : 2'b11;
            r_adr  <= w_adr[w_win];
            r_out  <= w_out[w_win];
        end else if (w_release) begin
            r_gnt  <= 2'b00;
        end
    end

    // error flag is high only for the DONE cycle that follows an expiry without ack
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= (r_state == S_BUSY) && w_expire && !bus.mem_ack;
    end

    // per-requester read-data registers, updated only when that requester's transaction ends
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [15:0] r_dat;

            // capture memory data on a read ack, zero on write ack or timeout
            always_ff @(posedge clk_p or negedge rst_n) begin
                if (!rst_n)
                    r_dat <= '0;
                else if (w_finish && r_gnt[gi])
                    r_dat <= (bus.mem_ack && !r_we) ? bus.mem_dat : 16'h0000;
            end

            assign w_dat[gi] = r_dat;
        end
    endgenerate

    assign bus.mem_stb = w_mem_stb;
    assign bus.mem_we  = r_we;
    assign bus.mem_sel = r_sel;
    assign bus.mem_adr = r_adr;
    assign bus.mem_out = r_out;
    assign bus.m0_ack  = w_ack[0];
    assign bus.m1_ack  = w_ack[1];
    assign bus.m0_dat  = w_dat[0];
    assign bus.m1_dat  = w_dat[1];
    assign bus.gnt     = r_gnt;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance carries the
// directed tests, a fixed-priority instance joins for the contention test.
module tb_mem_arbiter;
    logic clk_p   = 1'b0;
    logic rst_n   = 1'b1;
    logic rr_ack  = 1'b0;
    logic rr_auto = 1'b0;
    logic fp_ack  = 1'b0;
    logic fp_auto = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if if_rr ();
    mem_arbiter_if if_fp ();

    assign if_rr.mem_ack = rr_ack | (rr_auto & if_rr.mem_stb);
    assign if_fp.mem_ack = fp_ack | (fp_auto & if_fp.mem_stb);

    always #5 clk_p = ~clk_p;

    mem_arbiter #(.TIMEOUT(8), .RR_EN(1'b1)) u_dut_rr (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (if_rr.slave)
    );

    mem_arbiter #(.TIMEOUT(8), .RR_EN(1'b0)) u_dut_fp (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (if_fp.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_p);
        #1;
    endtask

    // requester drops its strobe after an ack and re-raises once it no longer owns the bus
    task automatic req_step(input logic ack, input logic owned, input logic cur,
                            inout logic waiting, output logic stb);
        stb = cur;
        if (ack) begin
            stb     = 1'b0;
            waiting = 1'b1;
        end else if (waiting && !owned) begin
            stb     = 1'b1;
            waiting = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic        seen;
        logic        s;
        logic        w_rr0, w_rr1, w_fp0, w_fp1;
        logic [1:0]  prev_rr, prev_fp;
        logic [1:0]  got_rr [4];
        logic [1:0]  got_fp [4];
        logic [1:0]  exp_rr [4];
        int          nrr, nfp, fp_m1_acks;

        if_rr.m0_stb = 0; if_rr.m0_we = 0; if_rr.m0_sel = 0; if_rr.m0_adr = 0; if_rr.m0_out = 0;
        if_rr.m1_stb = 0; if_rr.m1_we = 0; if_rr.m1_sel = 0; if_rr.m1_adr = 0; if_rr.m1_out = 0;
        if_rr.mem_dat = 0; if_rr.mem_ready = 0;
        if_fp.m0_stb = 0; if_fp.m0_we = 0; if_fp.m0_sel = 0; if_fp.m0_adr = 0; if_fp.m0_out = 0;
        if_fp.m1_stb = 0; if_fp.m1_we = 0; if_fp.m1_sel = 0; if_fp.m1_adr = 0; if_fp.m1_out = 0;
        if_fp.mem_dat = 0; if_fp.mem_ready = 0;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_stb", if_rr.mem_stb, 0);
        check("rst_gnt",     if_rr.gnt, 0);
        check("rst_err",     if_rr.err, 0);
        check("rst_m0_ack",  if_rr.m0_ack, 0);
        check("rst_m1_dat",  if_rr.m1_dat, 0);
        check("rst_mem_sel", if_rr.mem_sel, 0);
        check("rst_mem_adr", if_rr.mem_adr, 0);
        repeat (2) @(posedge clk_p);
        #3 rst_n = 1'b1;
        tick;
        $display("txn reset: done");

        // ---- single read by m0, ack two cycles into BUSY ----
        if_rr.mem_ready = 1; if_fp.mem_ready = 1;
        if_rr.m0_stb = 1; if_rr.m0_we = 0; if_rr.m0_sel = 2'b01;
        if_rr.m0_adr = 21'h000100; if_rr.m0_out = 16'hFFFF;
        tick;
        check("rd_gnt",  if_rr.gnt, 2'b01);
        check("rd_stb",  if_rr.mem_stb, 1);
        check("rd_sel",  if_rr.mem_sel, 2'b11);
        check("rd_adr",  if_rr.mem_adr, 21'h000100);
        check("rd_we",   if_rr.mem_we, 0);
        tick;
        check("rd_wait_stb", if_rr.mem_stb, 1);
        check("rd_wait_ack", if_rr.m0_ack, 0);
        rr_ack = 1; if_rr.mem_dat = 16'hA5C3;
        tick;
        rr_ack = 0;
        check("rd_ack",      if_rr.m0_ack, 1);
        check("rd_dat",      if_rr.m0_dat, 16'hA5C3);
        check("rd_m1_ack",   if_rr.m1_ack, 0);
        check("rd_done_stb", if_rr.mem_stb, 0);
        check("rd_err",      if_rr.err, 0);
        $display("txn m0 read adr=0x%0h dat=0x%0h", if_rr.mem_adr, if_rr.m0_dat);
        tick;
        check("rd_ack_pulse", if_rr.m0_ack, 0);
        check("rd_rel_gnt",   if_rr.gnt, 2'b01);
        if_rr.m0_stb = 0;
        tick;
        check("rd_idle_gnt", if_rr.gnt, 0);
        check("rd_dat_hold", if_rr.m0_dat, 16'hA5C3);

        // ---- byte write by m1, immediate ack ----
        if_rr.m1_stb = 1; if_rr.m1_we = 1; if_rr.m1_sel = 2'b10;
        if_rr.m1_adr = 21'h1F0000; if_rr.m1_out = 16'h1234;
        tick;
        check("wr_gnt", if_rr.gnt, 2'b10);
        check("wr_we",  if_rr.mem_we, 1);
        check("wr_sel", if_rr.mem_sel, 2'b10);
        check("wr_adr", if_rr.mem_adr, 21'h1F0000);
        check("wr_out", if_rr.mem_out, 16'h1234);
        rr_ack = 1; if_rr.mem_dat = 16'hBEEF;
        tick;
        rr_ack = 0;
        check("wr_ack",     if_rr.m1_ack, 1);
        check("wr_dat",     if_rr.m1_dat, 0);
        check("wr_m0_ack",  if_rr.m0_ack, 0);
        check("wr_m0_hold", if_rr.m0_dat, 16'hA5C3);
        $display("txn m1 write adr=0x%0h out=0x%0h", if_rr.mem_adr, if_rr.mem_out);
        if_rr.m1_stb = 0;
        tick; tick;
        check("wr_idle_gnt", if_rr.gnt, 0);

        // ---- timeout: no ack at all ----
        if_rr.m0_stb = 1; if_rr.m0_we = 0; if_rr.m0_sel = 2'b01; if_rr.m0_adr = 21'h40;
        cnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (if_rr.mem_stb) cnt++;
            if (if_rr.m0_ack) begin
                seen = 1;
                break;
            end
        end
        check("tmo_seen",    seen, 1);
        check("tmo_cycles",  cnt, 8);
        check("tmo_err",     if_rr.err, 1);
        check("tmo_dat",     if_rr.m0_dat, 0);
        check("tmo_mem_stb", if_rr.mem_stb, 0);
        $display("txn m0 timeout after %0d strobe cycles", cnt);
        tick;
        check("tmo_err_pulse", if_rr.err, 0);
        if_rr.m0_stb = 0;
        tick;

        // ---- ack arriving on the expiry cycle counts as a normal ack ----
        if_rr.m0_stb = 1; if_rr.m0_adr = 21'h41;
        tick;
        repeat (7) tick;
        check("edge_busy_stb", if_rr.mem_stb, 1);
        check("edge_busy_ack", if_rr.m0_ack, 0);
        rr_ack = 1; if_rr.mem_dat = 16'h5A5A;
        tick;
        rr_ack = 0;
        check("edge_ack", if_rr.m0_ack, 1);
        check("edge_err", if_rr.err, 0);
        check("edge_dat", if_rr.m0_dat, 16'h5A5A);
        $display("txn m0 read acked on expiry cycle dat=0x%0h", if_rr.m0_dat);
        if_rr.m0_stb = 0;
        tick; tick;

        // ---- mem_ready gating ----
        if_rr.mem_ready = 0;
        if_rr.m0_stb = 1; if_rr.m0_adr = 21'h2;
        cnt = 0;
        repeat (10) begin
            tick;
            if (if_rr.mem_stb) cnt++;
        end
        check("gate_stb_cycles", cnt, 0);
        check("gate_gnt",        if_rr.gnt, 0);
        if_rr.mem_ready = 1;
        tick;
        check("gate_release_stb", if_rr.mem_stb, 1);
        rr_ack = 1; if_rr.mem_dat = 16'h0F0F;
        tick;
        rr_ack = 0;
        check("gate_ack", if_rr.m0_ack, 1);
        check("gate_dat", if_rr.m0_dat, 16'h0F0F);
        $display("txn m0 read after mem_ready dat=0x%0h", if_rr.m0_dat);
        if_rr.m0_stb = 0;
        tick; tick;

        // ---- reset in the middle of BUSY with m1 pending ----
        if_rr.m0_stb = 1; if_rr.m0_adr = 21'h77;
        tick;
        check("rab_pre_gnt", if_rr.gnt, 2'b01);
        if_rr.m1_stb = 1; if_rr.m1_we = 1; if_rr.m1_sel = 2'b01;
        if_rr.m1_adr = 21'h55; if_rr.m1_out = 16'hCAFE;
        tick;
        rst_n = 0;
        #1;
        check("rab_mem_stb", if_rr.mem_stb, 0);
        check("rab_gnt",     if_rr.gnt, 0);
        check("rab_m0_ack",  if_rr.m0_ack, 0);
        check("rab_mem_adr", if_rr.mem_adr, 0);
        if_rr.m0_stb = 0;
        #1 rst_n = 1;
        tick;
        check("rab_m1_gnt", if_rr.gnt, 2'b10);
        check("rab_m1_adr", if_rr.mem_adr, 21'h55);
        check("rab_m1_we",  if_rr.mem_we, 1);
        check("rab_no_ack", if_rr.m0_ack, 0);
        rr_ack = 1;
        tick;
        rr_ack = 0;
        check("rab_m1_ack", if_rr.m1_ack, 1);
        $display("txn reset abort, then m1 write adr=0x%0h", if_rr.mem_adr);
        if_rr.m1_stb = 0;
        tick; tick;

        // ---- contention: both requesters keep asking, zero-wait memory ----
        if_rr.m0_we = 0; if_rr.m1_we = 0; if_fp.m0_we = 0; if_fp.m1_we = 0;
        if_rr.m0_stb = 1; if_rr.m1_stb = 1; if_fp.m0_stb = 1; if_fp.m1_stb = 1;
        rr_auto = 1; fp_auto = 1;
        w_rr0 = 0; w_rr1 = 0; w_fp0 = 0; w_fp1 = 0;
        prev_rr = 0; prev_fp = 0; nrr = 0; nfp = 0; fp_m1_acks = 0;
        for (int i = 0; i < 4; i++) begin
            got_rr[i] = 2'b00;
            got_fp[i] = 2'b00;
        end
        for (int c = 0; c < 80 && (nrr < 4 || nfp < 4); c++) begin
            tick;
            if (if_rr.gnt != 0 && prev_rr == 0 && nrr < 4) begin
                got_rr[nrr] = if_rr.gnt;
                $display("txn rr grant %0d gnt=%b", nrr, if_rr.gnt);
                nrr++;
            end
            if (if_fp.gnt != 0 && prev_fp == 0 && nfp < 4) begin
                got_fp[nfp] = if_fp.gnt;
                $display("txn fp grant %0d gnt=%b", nfp, if_fp.gnt);
                nfp++;
            end
            prev_rr = if_rr.gnt;
            prev_fp = if_fp.gnt;
            if (if_fp.m1_ack) fp_m1_acks++;
            req_step(if_rr.m0_ack, if_rr.gnt[0], if_rr.m0_stb, w_rr0, s); if_rr.m0_stb = s;
            req_step(if_rr.m1_ack, if_rr.gnt[1], if_rr.m1_stb, w_rr1, s); if_rr.m1_stb = s;
            req_step(if_fp.m0_ack, if_fp.gnt[0], if_fp.m0_stb, w_fp0, s); if_fp.m0_stb = s;
            req_step(if_fp.m1_ack, if_fp.gnt[1], if_fp.m1_stb, w_fp1, s); if_fp.m1_stb = s;
        end
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
        check("cont_rr_count", nrr, 4);
        check("cont_fp_count", nfp, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_rr_%0d", i), got_rr[i], exp_rr[i]);
            check($sformatf("cont_fp_%0d", i), got_fp[i], 2'b01);
        end
        check("cont_fp_m1_starved", fp_m1_acks, 0);
        rr_auto = 0; fp_auto = 0;
        if_rr.m0_stb = 0; if_rr.m1_stb = 0; if_fp.m0_stb = 0; if_fp.m1_stb = 0;
        repeat (3) tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
